// File: rtl/clock_phase_sequencer_pkg.sv
// Shared definitions for the clock phase sequencer: FSM state encoding and
// the width rule for the half-period counter.
package clock_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } seq_state_e;

    // clog2 of the half period, never narrower than one bit (HALF_PERIOD=1 still needs a register)
    function automatic int hp_count_width(input int half_period);
        int w;
        w = $clog2(half_period);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clock_phase_sequencer_if.sv
// Control/status bundle of the clock phase sequencer: run/step requests in,
// slow clock, edge strobes, step acknowledge and cycle counter out.
interface clock_phase_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             step_req;
    logic             slow_clk;
    logic             rise_en;
    logic             fall_en;
    logic             step_ack;
    logic             running;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output run,
        output step_req,
        input  slow_clk,
        input  rise_en,
        input  fall_en,
        input  step_ack,
        input  running,
        input  cycle_count
    );

    modport slave (
        input  run,
        input  step_req,
        output slow_clk,
        output rise_en,
        output fall_en,
        output step_ack,
        output running,
        output cycle_count
    );
endinterface

// File: rtl/clock_phase_sequencer_half_period_counter.sv
// Counts in_clk edges within one slow_clk half-period; terminal marks the
// edge on which slow_clk is due to toggle.
module clock_phase_sequencer_half_period_counter
    import clock_phase_sequencer_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int COUNT_W     = hp_count_width(HALF_PERIOD)
) (
    input  logic               in_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic               terminal
);
    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(HALF_PERIOD - 1);

    logic [COUNT_W-1:0] count_r;

    // Edge counter: wraps to zero on the terminal edge, clear dominates enable
    always_ff @(posedge in_clk) begin
        if (reset) begin
            count_r <= {COUNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {COUNT_W{1'b0}};
        end else if (enable) begin
            count_r <= terminal ? {COUNT_W{1'b0}} : count_r + COUNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign terminal = (count_r == LAST);

endmodule

// File: rtl/clock_phase_sequencer.sv
// Slow stage-clock generator with run/halt and single-step control, plus
// fast-domain rise/fall strobes and a slow-cycle counter for debug.
module clock_phase_sequencer
    import clock_phase_sequencer_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int CNT_W       = 32
) (
    input  logic                    in_clk,
    input  logic                    reset,
    clock_phase_sequencer_if.slave  bus
);
    localparam int HP_W = hp_count_width(HALF_PERIOD);

    seq_state_e       state_r;
    seq_state_e       next_state_s;
    logic             slow_clk_r;
    logic             slow_next_s;
    logic             rise_en_r;
    logic             rise_s;
    logic             fall_en_r;
    logic             fall_s;
    logic             step_ack_r;
    logic             ack_s;
    logic             running_r;
    logic             stop_pend_r;
    logic             stop_next_s;
    logic [CNT_W-1:0] cycle_count_r;

    logic [HP_W-1:0]  hp_count_s;
    logic             terminal_s;
    logic             hp_enable_s;
    logic             hp_clear_s;

    assign hp_enable_s = (state_r != ST_IDLE);
    assign hp_clear_s  = (state_r == ST_IDLE) && (hp_count_s != {HP_W{1'b0}});

    clock_phase_sequencer_half_period_counter #(
        .HALF_PERIOD (HALF_PERIOD),
        .COUNT_W     (HP_W)
    ) u_hp_cnt (
        .in_clk   (in_clk),
        .reset    (reset),
        .enable   (hp_enable_s),
        .clear    (hp_clear_s),
        .count    (hp_count_s),
        .terminal (terminal_s)
    );

    // Next state, next slow_clk level and strobe decisions for this edge
    always_comb begin
        next_state_s = state_r;
        slow_next_s  = slow_clk_r;
        rise_s       = 1'b0;
        fall_s       = 1'b0;
        ack_s        = 1'b0;
        stop_next_s  = stop_pend_r;

        case (state_r)
            ST_IDLE: begin
                slow_next_s = 1'b0;
                stop_next_s = 1'b0;
                if (bus.run) begin
                    next_state_s = ST_RUN;
                end else if (bus.step_req) begin
                    next_state_s = ST_STEP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (terminal_s && slow_clk_r) begin
                    slow_next_s  = 1'b0;
                    fall_s       = 1'b1;
                    stop_next_s  = 1'b0;
                    next_state_s = bus.run ? ST_RUN : ST_IDLE;
                end else if (terminal_s) begin
                    // A halt seen anywhere in the low half swallows the rise
                    if (!bus.run || stop_pend_r) begin
                        next_state_s = ST_IDLE;
                        stop_next_s  = 1'b0;
                    end else begin
                        slow_next_s = 1'b1;
                        rise_s      = 1'b1;
                    end
                end else if (!slow_clk_r && !bus.run) begin
                    stop_next_s = 1'b1;
                end else begin
                    stop_next_s = stop_pend_r;
                end
            end
            ST_STEP: begin
                if (terminal_s && slow_clk_r) begin
                    slow_next_s  = 1'b0;
                    fall_s       = 1'b1;
                    ack_s        = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (terminal_s) begin
                    slow_next_s = 1'b1;
                    rise_s      = 1'b1;
                end else begin
                    slow_next_s = slow_clk_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                slow_next_s  = 1'b0;
                stop_next_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            slow_clk_r    <= 1'b0;
            rise_en_r     <= 1'b0;
            fall_en_r     <= 1'b0;
            step_ack_r    <= 1'b0;
            running_r     <= 1'b0;
            stop_pend_r   <= 1'b0;
            cycle_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= next_state_s;
            slow_clk_r  <= slow_next_s;
            rise_en_r   <= rise_s;
            fall_en_r   <= fall_s;
            step_ack_r  <= ack_s;
            running_r   <= (next_state_s != ST_IDLE);
            stop_pend_r <= stop_next_s;
            if (rise_s) begin
                cycle_count_r <= cycle_count_r + CNT_W'(1);
            end else begin
                cycle_count_r <= cycle_count_r;
            end
        end
    end

    assign bus.slow_clk    = slow_clk_r;
    assign bus.rise_en     = rise_en_r;
    assign bus.fall_en     = fall_en_r;
    assign bus.step_ack    = step_ack_r;
    assign bus.running     = running_r;
    assign bus.cycle_count = cycle_count_r;

endmodule
